// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority-vote sampling and error reporting
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] HALF_CNT  = CW'(H);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_CLEANUP  = 3'd5,
    S_BRK_WAIT = 3'd6
  } state_t;

  // Line synchroniser and sample history
  logic       sync1_q;
  logic       sync2_q;
  logic [2:0] hist_q;
  logic       vote;

  // FSM and datapath state
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   xor_q, xor_d;
  logic                   par_bit_q, par_bit_d;
  logic                   perr_pend_q, perr_pend_d;
  logic                   ferr_pend_q, ferr_pend_d;

  // Registered outputs
  logic                   dv_q, dv_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;

  // Scratch terms used inside the next-state logic
  logic                   exp_par;
  logic                   ferr_now;

  // Two-flop synchroniser followed by a 3-deep history used for voting
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= i_Rx_Serial;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], sync2_q};
    end
  end

  // Bit decision: majority of the three most recent synchronised samples
  assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  // State, counters, pending flags and output registers
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      xor_q       <= 1'b0;
      par_bit_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      dv_q        <= 1'b0;
      byte_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      xor_q       <= xor_d;
      par_bit_q   <= par_bit_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      dv_q        <= dv_d;
      byte_q      <= byte_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
    end
  end

  // Next-state and datapath: every bit is decided at its terminal count
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    xor_d       = xor_q;
    par_bit_d   = par_bit_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    dv_d        = 1'b0;
    byte_d      = byte_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;
    exp_par     = (PARITY == 2) ? xor_q : ~xor_q;
    ferr_now    = ferr_pend_q | ~vote;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!sync2_q) begin
          state_d     = S_START;
          shift_d     = '0;
          xor_d       = 1'b0;
          par_bit_d   = 1'b0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end

      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          // A start bit that is high again at mid-bit was a glitch
          state_d = vote ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = vote;
          xor_d          = xor_q ^ vote;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          idx_d     = '0;
          par_bit_d = vote;
          if (vote != exp_par) begin
            perr_pend_d = 1'b1;
          end
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          ferr_pend_d = ferr_now;
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            dv_d    = 1'b1;
            byte_d  = shift_q;
            perr_d  = perr_pend_q;
            ferr_d  = ferr_now;
            // A break is a framing error on an all-zero frame, parity bit included
            brk_d   = ferr_now & (shift_q == '0) & ((PARITY == 0) | ~par_bit_q);
            // After a bad stop the line may still be low; wait for it to release
            state_d = ferr_now ? S_BRK_WAIT : S_CLEANUP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CLEANUP: begin
        state_d = S_IDLE;
      end

      S_BRK_WAIT: begin
        cnt_d = '0;
        idx_d = '0;
        if (sync2_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != S_IDLE);

endmodule
